// File: rtl/axi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : axi_pkg                                                           |
// | Brief  : AXI constants, checker state encoding and the burst length table  |
// |          shared by the read checker and the write generator.              |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'd2;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } rd_state_e;

  // arlen for burst k; bursts beyond the third are single-beat
  function automatic logic [3:0] burst_len(input logic [4:0] k);
    case (k)
      5'd0:    burst_len = 4'd3;
      5'd1:    burst_len = 4'd7;
      5'd2:    burst_len = 4'd15;
      default: burst_len = 4'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_rd_beat_chk.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : axi_rd_beat_chk                                                   |
// | Brief  : Combinational compare of one read beat against the written       |
// |          pattern; flags any data, ID, response or rlast discrepancy.      |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module axi_rd_beat_chk
  import axi_pkg::*;
#(
  parameter int DW   = 32,
  parameter int ID_W = 4
) (
  input  logic [DW-1:0]   rdata_i,
  input  logic [ID_W-1:0] rid_i,
  input  logic [1:0]      rresp_i,
  input  logic            rlast_i,
  input  logic [4:0]      rb_i,
  input  logic [7:0]      bt_i,
  input  logic [3:0]      len_i,
  output logic            err_beat_o
);

  logic [DW-1:0] w_exp_data;
  logic          w_exp_last;

  assign w_exp_data = DW'({rb_i[3:0], bt_i[3:0]});
  assign w_exp_last = (bt_i == {4'd0, len_i});

  assign err_beat_o = (rdata_i != w_exp_data)
                    | (32'(rid_i) != 32'(rb_i))
                    | (rresp_i != RESP_OKAY)
                    | (rlast_i != w_exp_last);

endmodule
`default_nettype wire

// File: rtl/axi_rd_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : axi_rd_checker                                                    |
// | Brief  : AXI4 read traffic checker; issues a fixed INCR burst schedule and |
// |          counts beats that differ from the generator's pattern.           |
// |          AXI_RD_CHK_BP_EN: rready pulses 1 cycle in 4 to stress the slave. |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module axi_rd_checker
  import axi_pkg::*;
#(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int ID_W            = 4,
  parameter int NUM_BURST       = 3,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  output logic            arvalid,
  input  logic            arready,
  output logic [AW-1:0]   araddr,
  output logic [ID_W-1:0] arid,
  output logic [3:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  input  logic            rvalid,
  output logic            rready,
  input  logic [DW-1:0]   rdata,
  input  logic            rlast,
  input  logic [ID_W-1:0] rid,
  input  logic [1:0]      rresp,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [7:0]      err_cnt
);

  localparam int             OW          = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0]  C_MAX_OUT   = OW'(MAX_OUTSTANDING);
  localparam logic [4:0]     C_NUM_BURST = 5'(NUM_BURST);

  rd_state_e       state_q, state_d;
  logic [4:0]      arcnt_q, arcnt_d;
  logic [4:0]      rb_q, rb_d;
  logic [7:0]      bt_q, bt_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic [OW-1:0]   outst_q, outst_d;
  logic            arvalid_q, arvalid_d;
  logic [AW-1:0]   araddr_q, araddr_d;
  logic [ID_W-1:0] arid_q, arid_d;
  logic [3:0]      arlen_q, arlen_d;

  logic w_ar_hs, w_r_hs, w_last_hs, w_err_beat, w_run;

  assign w_run     = (state_q == ST_RUN);
  assign w_ar_hs   = arvalid_q & arready;
  assign w_r_hs    = rvalid & rready;
  assign w_last_hs = w_r_hs & rlast;

  axi_rd_beat_chk #(
    .DW   (DW),
    .ID_W (ID_W)
  ) u_beat_chk (
    .rdata_i    (rdata),
    .rid_i      (rid),
    .rresp_i    (rresp),
    .rlast_i    (rlast),
    .rb_i       (rb_q),
    .bt_i       (bt_q),
    .len_i      (burst_len(rb_q)),
    .err_beat_o (w_err_beat)
  );

`ifdef AXI_RD_CHK_BP_EN
  logic [1:0] bp_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) bp_cnt_q <= 2'd0;
    else       bp_cnt_q <= bp_cnt_q + 2'd1;
  end

  assign rready = w_run & (bp_cnt_q == 2'd0);
`else
  assign rready = w_run;
`endif

  always_comb begin
    state_d   = state_q;
    arcnt_d   = arcnt_q;
    rb_d      = rb_q;
    bt_d      = bt_q;
    err_cnt_d = err_cnt_q;
    outst_d   = outst_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arid_d    = arid_q;
    arlen_d   = arlen_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // First AR is presented together with entry into RUN
        if (start) begin
          state_d   = ST_RUN;
          arcnt_d   = 5'd0;
          rb_d      = 5'd0;
          bt_d      = 8'd0;
          err_cnt_d = 8'd0;
          outst_d   = '0;
          arvalid_d = 1'b1;
          araddr_d  = '0;
          arid_d    = '0;
          arlen_d   = burst_len(5'd0);
        end
      end

      ST_RUN: begin
        if (w_ar_hs) begin
          arvalid_d = 1'b0;
          arcnt_d   = arcnt_q + 5'd1;
        end else if (!arvalid_q && (arcnt_q < C_NUM_BURST) && (outst_q < C_MAX_OUT)) begin
          arvalid_d = 1'b1;
          araddr_d  = AW'(arcnt_q) << 8;
          arid_d    = ID_W'(arcnt_q);
          arlen_d   = burst_len(arcnt_q);
        end

        if (w_ar_hs && !w_last_hs) begin
          outst_d = outst_q + OW'(1);
        end else if (!w_ar_hs && w_last_hs && (outst_q != '0)) begin
          outst_d = outst_q - OW'(1);
        end

        if (w_r_hs) begin
          if ((w_err_beat || (outst_q == '0)) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
          // rlast always closes the burst, even if it arrives early
          if (rlast) begin
            bt_d = 8'd0;
            rb_d = rb_q + 5'd1;
            if ((rb_q + 5'd1) == C_NUM_BURST) begin
              state_d = ST_DONE;
            end
          end else begin
            bt_d = bt_q + 8'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      arcnt_q   <= 5'd0;
      rb_q      <= 5'd0;
      bt_q      <= 8'd0;
      err_cnt_q <= 8'd0;
      outst_q   <= '0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arid_q    <= '0;
      arlen_q   <= 4'd0;
    end else begin
      state_q   <= state_d;
      arcnt_q   <= arcnt_d;
      rb_q      <= rb_d;
      bt_q      <= bt_d;
      err_cnt_q <= err_cnt_d;
      outst_q   <= outst_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arid_q    <= arid_d;
      arlen_q   <= arlen_d;
    end
  end

  assign arvalid = arvalid_q;
  assign araddr  = araddr_q;
  assign arid    = arid_q;
  assign arlen   = arlen_q;
  assign arsize  = SIZE_4B;
  assign arburst = BURST_INCR;
  assign busy    = w_run;
  assign done    = (state_q == ST_DONE);
  assign pass    = done & (err_cnt_q == 8'd0);
  assign err_cnt = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_axi_rd_checker                                                 |
// | Brief  : Directed bench with an in-order slave model and AR/result         |
// |          scoreboards for axi_rd_checker.                                   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_axi_rd_checker;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int IDW = 4;
  localparam int NB  = 3;
  localparam int MO  = 2;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           start = 1'b0;
  logic           arready = 1'b0;
  logic           rvalid = 1'b0;
  logic           rlast = 1'b0;
  logic [DW-1:0]  rdata = '0;
  logic [IDW-1:0] rid = '0;
  logic [1:0]     rresp = 2'b00;
  logic           arvalid, rready, busy, done, pass;
  logic [AW-1:0]  araddr;
  logic [IDW-1:0] arid;
  logic [3:0]     arlen;
  logic [2:0]     arsize;
  logic [1:0]     arburst;
  logic [7:0]     err_cnt;

  axi_rd_checker #(
    .AW(AW), .DW(DW), .ID_W(IDW), .NUM_BURST(NB), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast),
    .rid(rid), .rresp(rresp),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]  addr;
    logic [IDW-1:0] id;
    logic [3:0]     len;
  } ar_t;

  ar_t exp_ar_q[$];
  ar_t slv_q[$];
  int  exp_err_q[$];

  int checks = 0;
  int failures = 0;

  int inj_data_b = -1, inj_data_bt = -1;
  int inj_resp_b = -1, inj_resp_bt = -1;
  int inj_rid_b = -1, inj_rid_bt = -1, inj_rid_val = 0;
  int inj_early_b = -1, inj_early_bt = -1;

  function automatic logic [3:0] exp_len(input int k);
    if (k == 0)      return 4'd3;
    else if (k == 1) return 4'd7;
    else if (k == 2) return 4'd15;
    else             return 4'd0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_arvalid"}, arvalid, 0);
    chk({tag, "_araddr"},  araddr, 0);
    chk({tag, "_arid"},    arid, 0);
    chk({tag, "_arlen"},   arlen, 0);
    chk({tag, "_rready"},  rready, 0);
    chk({tag, "_busy"},    busy, 0);
    chk({tag, "_done"},    done, 0);
    chk({tag, "_pass"},    pass, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_arsize"},  arsize, 3'd2);
    chk({tag, "_arburst"}, arburst, 2'b01);
  endtask

  task automatic clear_inj();
    inj_data_b = -1;  inj_data_bt = -1;
    inj_resp_b = -1;  inj_resp_bt = -1;
    inj_rid_b = -1;   inj_rid_bt = -1;  inj_rid_val = 0;
    inj_early_b = -1; inj_early_bt = -1;
  endtask

  // One run; abort_rl >= 0 pulls rstn once abort_rl bursts are done and abort_bt beats seen
  task automatic run(input int exp_err, input int stall, input int abort_rl, input int abort_bt);
    int         beat, out_m, rl_cnt, stall_left, ar_seen, exp_e, b;
    bit         fin, last_pend, prev_stall, prev_rready;
    logic [AW-1:0] prev_addr;
    ar_t        cur, got, expv;
    logic [3:0] b4, bt4;
    beat = 0; out_m = 0; rl_cnt = 0; stall_left = stall; ar_seen = 0;
    fin = 1'b0; last_pend = 1'b0; prev_stall = 1'b0; prev_rready = 1'b0;
    prev_addr = '0;
    slv_q.delete();
    for (int k = 0; k < NB; k++) exp_ar_q.push_back('{AW'(k << 8), IDW'(k), exp_len(k)});
    exp_err_q.push_back(exp_err);

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("arvalid_1cyc_after_start", arvalid, 1);
    chk("busy_in_run", busy, 1);
    chk("done_cleared", done, 0);

    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (last_pend) begin
        exp_e = exp_err_q.pop_front();
        chk("done_after_last", done, 1);
        chk("busy_drop", busy, 0);
        chk("err_cnt_final", err_cnt, exp_e);
        chk("pass_final", pass, (exp_e == 0));
        chk("rready_off_done", rready, 0);
        chk("ar_all_issued", exp_ar_q.size(), 0);
        fin = 1'b1;
      end else if (abort_rl >= 0 && rl_cnt == abort_rl && beat == abort_bt) begin
        rstn = 1'b0; rvalid = 1'b0; rlast = 1'b0; arready = 1'b0;
        #1;
        chk_reset("midrun_reset");
        exp_ar_q.delete();
        void'(exp_err_q.pop_back());
        slv_q.delete();
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        fin = 1'b1;
      end else begin
        arready = (stall_left == 0);
        if (arvalid && stall_left > 0) stall_left--;
        if (prev_stall) begin
          chk("arvalid_hold", arvalid, 1);
          chk("araddr_stable", araddr, prev_addr);
        end
        prev_stall = arvalid && !arready;
        prev_addr  = araddr;

`ifdef AXI_RD_CHK_BP_EN
        chk("rready_bp_sparse", (rready && prev_rready), 0);
`else
        chk("rready_in_run", rready, 1);
`endif
        prev_rready = rready;

        if (slv_q.size() > 0) begin
          cur = slv_q[0];
          b4  = cur.addr[11:8];
          bt4 = beat[3:0];
          b   = int'(b4);
          rvalid = 1'b1;
          rdata  = DW'({b4, bt4});
          rid    = cur.id;
          rresp  = 2'b00;
          rlast  = (beat == int'(cur.len));
          if (b == inj_data_b  && beat == inj_data_bt)  rdata = '0;
          if (b == inj_resp_b  && beat == inj_resp_bt)  rresp = 2'b10;
          if (b == inj_rid_b   && beat == inj_rid_bt)   rid = IDW'(inj_rid_val);
          if (b == inj_early_b && beat == inj_early_bt) rlast = 1'b1;
        end else begin
          rvalid = 1'b0;
          rlast  = 1'b0;
        end

        if (arvalid && arready) begin
          got = '{araddr, arid, arlen};
          if (exp_ar_q.size() == 0) begin
            chk("ar_unexpected", got, 0);
          end else begin
            expv = exp_ar_q.pop_front();
            chk("ar_fields", got, expv);
          end
          chk("ar_outstanding_limit", (out_m < MO), 1);
          if (ar_seen == 2) chk("ar3_after_rlast0", (rl_cnt >= 1), 1);
          slv_q.push_back(got);
          out_m++;
          ar_seen++;
        end

        if (rvalid && rready) begin
          if (rlast) begin
            void'(slv_q.pop_front());
            beat = 0;
            out_m--;
            rl_cnt++;
            if (rl_cnt == NB) last_pend = 1'b1;
          end else begin
            beat++;
          end
        end
        @(negedge clk);
      end
    end
    chk("run_completed", fin, 1);
    rvalid = 1'b0;
    rlast = 1'b0;
    arready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("por");
    rstn = 1'b1;
    @(negedge clk);

    clear_inj();
    run(0, 0, -1, -1);

    clear_inj();
    inj_data_b = 1; inj_data_bt = 5;
    run(1, 0, -1, -1);

    clear_inj();
    inj_resp_b = 2; inj_resp_bt = 0;
    inj_rid_b = 2;  inj_rid_bt = 1;  inj_rid_val = 3;
    run(2, 0, -1, -1);

    clear_inj();
    inj_early_b = 0; inj_early_bt = 2;
    run(1, 0, -1, -1);

    clear_inj();
    run(0, 10, -1, -1);

    clear_inj();
    run(0, 0, 1, 3);
    run(0, 0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
